// File: rtl/pc_ras.sv
// Program counter with an integrated circular return-address stack.
// Handles increment, relative branch, absolute jump, call (jump + push) and return (pop).
module pc_ras #(
  parameter int               WIDTH        = 16,
  parameter int               DISP_WIDTH   = 8,
  parameter int               DEPTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pcEn,
  input  logic                         branch,
  input  logic                         jump,
  input  logic                         call,
  input  logic                         ret,
  input  logic [DISP_WIDTH-1:0]        disp,
  input  logic [WIDTH-1:0]             dSrc,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_ra,
  output logic [WIDTH-1:0]             ras_top,
  output logic [$clog2(DEPTH):0]       ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int             PW       = $clog2(DEPTH);
  localparam int             CW       = PW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    OP_INC,
    OP_BRANCH,
    OP_JUMP,
    OP_RET
  } op_e;

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] pc_q;
  logic [PW-1:0]    ptr_q;
  logic [CW-1:0]    count_q;
  logic             ovf_q;
  logic             udf_q;

  logic [WIDTH-1:0] disp_sext;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_br;
  logic [WIDTH-1:0] pc_n;
  logic [PW-1:0]    ptr_push;
  logic [PW-1:0]    ptr_pop;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;
  op_e              op;

  assign disp_sext = {{(WIDTH-DISP_WIDTH){disp[DISP_WIDTH-1]}}, disp};
  assign pc_inc    = pc_q + WIDTH'(1);
  assign pc_br     = pc_q + disp_sext;
  assign ptr_push  = ptr_q + PW'(1);
  assign ptr_pop   = ptr_q - PW'(1);
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);

  always_comb begin
    op      = OP_INC;
    pc_n    = pc_inc;
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (ret)         op = OP_RET;
    else if (jump)   op = OP_JUMP;
    else if (branch) op = OP_BRANCH;
    case (op)
      OP_RET: begin
        do_pop = 1'b1;
        pc_n   = empty ? dSrc : stack_q[ptr_q];
      end
      OP_JUMP: begin
        pc_n    = dSrc;
        do_push = call;
      end
      OP_BRANCH: pc_n = pc_br;
      default:   pc_n = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      ptr_q   <= '1;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (pcEn) begin
      pc_q <= pc_n;
      if (do_push) begin
        // Circular: when full the pointer still advances, overwriting the oldest entry.
        ptr_q <= ptr_push;
        if (full) ovf_q <= 1'b1;
        else      count_q <= count_q + CW'(1);
      end else if (do_pop) begin
        if (empty) begin
          udf_q <= 1'b1;
        end else begin
          ptr_q   <= ptr_pop;
          count_q <= count_q - CW'(1);
        end
      end
    end
  end

  // Storage needs no reset; ras_top is masked while the stack is empty.
  always_ff @(posedge clk) begin
    if (!rst && pcEn && do_push) stack_q[ptr_push] <= pc_inc;
  end

  assign pc            = pc_q;
  assign pc_ra         = branch ? pc_br : pc_inc;
  assign ras_top       = empty ? '0 : stack_q[ptr_q];
  assign ras_count     = count_q;
  assign ras_empty     = empty;
  assign ras_full      = full;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = udf_q;

endmodule

// File: tb/tb_pc_ras.sv
// Directed, table-driven bench for pc_ras (WIDTH=16, DISP_WIDTH=8, DEPTH=4, RESET_VECTOR=0).
module tb_pc_ras;

  localparam int W  = 16;
  localparam int DW = 8;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst, pcEn, branch, jump, call, ret;
  logic [DW-1:0] disp;
  logic [W-1:0]  dSrc, pc, pc_ra, ras_top;
  logic [CW-1:0] ras_count;
  logic          ras_empty, ras_full, ras_overflow, ras_underflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, en, br, jmp, cl, rt;
    logic [7:0]  disp;
    logic [15:0] dsrc;
    logic [15:0] pc;
    logic [15:0] top;
    logic [2:0]  cnt;
    logic        ovf, udf;
  } vec_t;

  vec_t vecs[$];

  pc_ras #(.WIDTH(W), .DISP_WIDTH(DW), .DEPTH(D), .RESET_VECTOR(16'h0000)) dut (
    .clk(clk), .rst(rst), .pcEn(pcEn), .branch(branch), .jump(jump), .call(call),
    .ret(ret), .disp(disp), .dSrc(dSrc), .pc(pc), .pc_ra(pc_ra), .ras_top(ras_top),
    .ras_count(ras_count), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, en, br, jmp, cl, rt, input logic [7:0] dp,
                              input logic [15:0] ds, epc, etop, input logic [2:0] ecnt,
                              input logic eovf, eudf);
    vec_t v;
    v.rst = r; v.en = en; v.br = br; v.jmp = jmp; v.cl = cl; v.rt = rt;
    v.disp = dp; v.dsrc = ds; v.pc = epc; v.top = etop; v.cnt = ecnt;
    v.ovf = eovf; v.udf = eudf;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic r, en, br, jmp, cl, rt, input logic [7:0] dp,
                       input logic [15:0] ds);
    rst = r; pcEn = en; branch = br; jump = jmp; call = cl; ret = rt;
    disp = dp; dSrc = ds;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 8'h00, 16'h0000);
  endtask

  initial begin
    idle();
    //             rst en br jp cl rt disp   dSrc      pc        top       cnt ovf udf
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0001, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0002, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0003, 16'h0000, 0, 0, 0));
    // branch arithmetic and wrap
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0001, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 8'h7f, 16'h0000, 16'h0080, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 8'h81, 16'h0000, 16'h0001, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 8'hff, 16'h0000, 16'hffff, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
    // call / return
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 8'h00, 16'h0010, 16'h0010, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 8'h00, 16'h8000, 16'h8000, 16'h0011, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 8'h00, 16'hffff, 16'hffff, 16'h8001, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 8'h00, 16'h0000, 16'h8001, 16'h0011, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 8'h00, 16'h0000, 16'h0011, 16'h0000, 0, 0, 0));
    // overflow: fifth call overwrites the oldest entry
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 8'h00, 16'h0100, 16'h0100, 16'h0001, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 8'h00, 16'h0200, 16'h0200, 16'h0101, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 8'h00, 16'h0300, 16'h0300, 16'h0201, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 8'h00, 16'h0400, 16'h0400, 16'h0301, 4, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 8'h00, 16'h0500, 16'h0500, 16'h0401, 4, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 8'h00, 16'h0000, 16'h0401, 16'h0301, 3, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 8'h00, 16'h0000, 16'h0301, 16'h0201, 2, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 8'h00, 16'h0000, 16'h0201, 16'h0101, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 8'h00, 16'h0000, 16'h0101, 16'h0000, 0, 1, 0));
    // underflow, then enable gating
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 8'h00, 16'h1234, 16'h1234, 16'h0000, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h1235, 16'h0000, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 8'h00, 16'h8000, 16'h1235, 16'h0000, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 16'h4444, 16'h1235, 16'h0000, 0, 1, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
    // ret beats jump/call/branch; no push
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 8'h00, 16'h0040, 16'h0040, 16'h0001, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 1, 8'h05, 16'h9999, 16'h0001, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 8'h00, 16'h0050, 16'h0050, 16'h0002, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 16'h0000, 16'h0050, 16'h0002, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 8'h00, 16'h7777, 16'h0050, 16'h0002, 1, 0, 0));
    // reset during a call, then a ret must underflow
    vecs.push_back(mk(1, 1, 0, 1, 1, 0, 8'h00, 16'h3000, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 8'h00, 16'h0abc, 16'h0abc, 16'h0000, 0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].br, vecs[i].jmp, vecs[i].cl, vecs[i].rt,
            vecs[i].disp, vecs[i].dsrc);
      @(posedge clk);
      #1;
      check("pc", i, 32'(pc), 32'(vecs[i].pc));
      check("ras_top", i, 32'(ras_top), 32'(vecs[i].top));
      check("ras_count", i, 32'(ras_count), 32'(vecs[i].cnt));
      check("ras_empty", i, 32'(ras_empty), 32'(vecs[i].cnt == 3'd0));
      check("ras_full", i, 32'(ras_full), 32'(vecs[i].cnt == 3'd4));
      check("ras_overflow", i, 32'(ras_overflow), 32'(vecs[i].ovf));
      check("ras_underflow", i, 32'(ras_underflow), 32'(vecs[i].udf));
    end

    // pc_ra is combinational and tracks inputs even with pcEn low
    drive(1, 0, 0, 0, 0, 0, 8'h00, 16'h0000);
    @(posedge clk); #1;
    idle();
    #1;
    check("pc_ra_reset", 100, 32'(pc_ra), 32'h0001);
    branch = 1'b1; disp = 8'hff;
    #1;
    check("pc_ra_neg", 101, 32'(pc_ra), 32'hffff);
    disp = 8'h7f;
    #1;
    check("pc_ra_pos", 102, 32'(pc_ra), 32'h007f);
    @(posedge clk); #1;
    check("pc_hold_en0", 103, 32'(pc), 32'h0000);

    // sticky underflow persists across many cycles until reset
    drive(0, 1, 0, 0, 0, 1, 8'h00, 16'hfffe);
    @(posedge clk); #1;
    check("udf_pc", 104, 32'(pc), 32'hfffe);
    drive(0, 1, 0, 0, 0, 0, 8'h00, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("udf_sticky", 105 + k, 32'(ras_underflow), 32'h1);
    end
    check("pc_wrap_inc", 109, 32'(pc), 32'h0002);
    drive(1, 0, 0, 0, 0, 0, 8'h00, 16'h0000);
    @(posedge clk); #1;
    check("udf_cleared", 110, 32'(ras_underflow), 32'h0);

    // push then immediate ret returns the just-pushed value
    drive(0, 1, 0, 1, 1, 0, 8'h00, 16'h2000);
    @(posedge clk); #1;
    drive(0, 1, 0, 0, 0, 1, 8'h00, 16'h0000);
    @(posedge clk); #1;
    check("push_ret_pc", 111, 32'(pc), 32'h0001);
    check("push_ret_cnt", 111, 32'(ras_count), 32'h0);

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
